// File: rtl/hawk_tbl_wr_mngr.sv
// Table write manager: takes one ATT + TOL list update per request, writes both to DRAM
// over a single-beat AXI4 write master (ATT first), then pulses the new free-list head.
module hawk_tbl_wr_mngr #(
   parameter logic [63:0] ATT_BASE = 64'h0,
   parameter logic [63:0] LST_BASE = 64'h0,
   parameter int          ATT_ID_W = 16,
   parameter int          LST_ID_W = 16,
   parameter int          AXI_DW   = 512
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  tbl_update,
   input  logic [ATT_ID_W-1:0]   upd_att_id,
   input  logic [63:0]           upd_att_entry,
   input  logic [LST_ID_W-1:0]   upd_tol_id,
   input  logic [127:0]          upd_lst_entry,
   input  logic [LST_ID_W-1:0]   upd_lst_next,
   output logic                  upd_ready,
   output logic                  awvalid,
   input  logic                  awready,
   output logic [63:0]           awaddr,
   output logic                  wvalid,
   input  logic                  wready,
   output logic [AXI_DW-1:0]     wdata,
   output logic [AXI_DW/8-1:0]   wstrb,
   output logic                  wlast,
   input  logic                  bvalid,
   input  logic [1:0]            bresp,
   output logic                  bready,
   output logic                  head_upd,
   output logic [LST_ID_W-1:0]   head_new,
   output logic                  wr_error
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ATT_WR = 3'd1,
      S_ATT_B  = 3'd2,
      S_LST_WR = 3'd3,
      S_LST_B  = 3'd4,
      S_DONE   = 3'd5,
      S_ERR    = 3'd6
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [ATT_ID_W-1:0]  r_att_id;
   logic [63:0]          r_att_entry;
   logic [LST_ID_W-1:0]  r_tol_id;
   logic [127:0]         r_lst_entry;
   logic [LST_ID_W-1:0]  r_lst_next;

   logic                 r_upd_ready;
   logic                 r_awvalid;
   logic                 r_wvalid;
   logic                 r_bready;
   logic                 r_head_upd;
   logic                 r_wr_error;
   logic [63:0]          r_awaddr;
   logic [AXI_DW-1:0]    r_wdata;
   logic [AXI_DW/8-1:0]  r_wstrb;
   logic [LST_ID_W-1:0]  r_head_new;
   logic                 r_issued;
   logic                 r_aw_done;
   logic                 r_w_done;

   logic                 w_aw_hs;
   logic                 w_w_hs;
   logic                 w_wr_fin;
   logic                 w_b_hs;
   logic                 w_b_ok;
   logic                 w_b_err;
   logic [63:0]          w_att_idx;
   logic [63:0]          w_lst_idx;
   logic [63:0]          w_att_addr;
   logic [63:0]          w_lst_addr;
   logic [AXI_DW/8-1:0]  w_att_strb;
   logic [AXI_DW/8-1:0]  w_lst_strb;
   logic [AXI_DW-1:0]    w_att_data;
   logic [AXI_DW-1:0]    w_lst_data;

   // A write phase finishes once both channels have handshaken, in any order.
   assign w_aw_hs  = r_awvalid & awready;
   assign w_w_hs   = r_wvalid & wready;
   assign w_wr_fin = r_issued & (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);
   assign w_b_hs   = r_bready & bvalid;
   assign w_b_ok   = w_b_hs & (bresp == 2'b00);
   assign w_b_err  = w_b_hs & (bresp != 2'b00);

   // Eight 64-bit ATT entries or four 128-bit list entries per 64-byte cacheline.
   assign w_att_idx  = {{(64-ATT_ID_W){1'b0}}, r_att_id};
   assign w_lst_idx  = {{(64-LST_ID_W){1'b0}}, r_tol_id};
   assign w_att_addr = ATT_BASE + ((w_att_idx >> 3) << 6);
   assign w_lst_addr = LST_BASE + ((w_lst_idx >> 2) << 6);
   assign w_att_strb = {{(AXI_DW/8-8){1'b0}}, 8'hFF} << {r_att_id[2:0], 3'b000};
   assign w_lst_strb = {{(AXI_DW/8-16){1'b0}}, 16'hFFFF} << {r_tol_id[1:0], 4'b0000};
   assign w_att_data = {(AXI_DW/64){r_att_entry}};
   assign w_lst_data = {(AXI_DW/128){r_lst_entry}};

   assign upd_ready = r_upd_ready;
   assign awvalid   = r_awvalid;
   assign awaddr    = r_awaddr;
   assign wvalid    = r_wvalid;
   assign wdata     = r_wdata;
   assign wstrb     = r_wstrb;
   assign wlast     = 1'b1;
   assign bready    = r_bready;
   assign head_upd  = r_head_upd;
   assign head_new  = r_head_new;
   assign wr_error  = r_wr_error;

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (tbl_update) w_state_nxt = S_ATT_WR;
            else            w_state_nxt = S_IDLE;
         end
         S_ATT_WR: begin
            if (w_wr_fin) w_state_nxt = S_ATT_B;
            else          w_state_nxt = S_ATT_WR;
         end
         S_ATT_B: begin
            if (w_b_err)     w_state_nxt = S_ERR;
            else if (w_b_ok) w_state_nxt = S_LST_WR;
            else             w_state_nxt = S_ATT_B;
         end
         S_LST_WR: begin
            if (w_wr_fin) w_state_nxt = S_LST_B;
            else          w_state_nxt = S_LST_WR;
         end
         S_LST_B: begin
            if (w_b_err)     w_state_nxt = S_ERR;
            else if (w_b_ok) w_state_nxt = S_DONE;
            else             w_state_nxt = S_LST_B;
         end
         S_DONE:  w_state_nxt = S_IDLE;
         S_ERR:   w_state_nxt = S_ERR;
         default: w_state_nxt = S_ERR;
      endcase
   end

   // Capture registers and registered AXI / head outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_att_id    <= '0;
         r_att_entry <= 64'h0;
         r_tol_id    <= '0;
         r_lst_entry <= 128'h0;
         r_lst_next  <= '0;
         r_upd_ready <= 1'b1;
         r_awvalid   <= 1'b0;
         r_wvalid    <= 1'b0;
         r_bready    <= 1'b0;
         r_head_upd  <= 1'b0;
         r_wr_error  <= 1'b0;
         r_awaddr    <= 64'h0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
         r_head_new  <= '0;
         r_issued    <= 1'b0;
         r_aw_done   <= 1'b0;
         r_w_done    <= 1'b0;
      end else begin
         r_head_upd <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (tbl_update) begin
                  r_att_id    <= upd_att_id;
                  r_att_entry <= upd_att_entry;
                  r_tol_id    <= upd_tol_id;
                  r_lst_entry <= upd_lst_entry;
                  r_lst_next  <= upd_lst_next;
                  r_upd_ready <= 1'b0;
               end
            end
            S_ATT_WR, S_LST_WR: begin
               // First cycle of a write phase loads the beat; later cycles track handshakes.
               if (!r_issued) begin
                  r_issued  <= 1'b1;
                  r_awvalid <= 1'b1;
                  r_wvalid  <= 1'b1;
                  r_aw_done <= 1'b0;
                  r_w_done  <= 1'b0;
                  if (r_state == S_ATT_WR) begin
                     r_awaddr <= w_att_addr;
                     r_wdata  <= w_att_data;
                     r_wstrb  <= w_att_strb;
                  end else begin
                     r_awaddr <= w_lst_addr;
                     r_wdata  <= w_lst_data;
                     r_wstrb  <= w_lst_strb;
                  end
               end else if (w_wr_fin) begin
                  r_awvalid <= 1'b0;
                  r_wvalid  <= 1'b0;
                  r_aw_done <= 1'b0;
                  r_w_done  <= 1'b0;
                  r_issued  <= 1'b0;
                  r_bready  <= 1'b1;
               end else begin
                  if (w_aw_hs) begin
                     r_awvalid <= 1'b0;
                     r_aw_done <= 1'b1;
                  end
                  if (w_w_hs) begin
                     r_wvalid <= 1'b0;
                     r_w_done <= 1'b1;
                  end
               end
            end
            S_ATT_B, S_LST_B: begin
               if (w_b_hs) begin
                  r_bready <= 1'b0;
                  if (w_b_err) r_wr_error <= 1'b1;
               end
            end
            S_DONE: begin
               r_head_upd  <= 1'b1;
               r_head_new  <= r_lst_next;
               r_upd_ready <= 1'b1;
            end
            S_ERR: begin
               r_wr_error  <= 1'b1;
               r_upd_ready <= 1'b0;
               r_awvalid   <= 1'b0;
               r_wvalid    <= 1'b0;
               r_bready    <= 1'b0;
            end
            default: begin
               r_wr_error  <= 1'b1;
               r_upd_ready <= 1'b0;
               r_awvalid   <= 1'b0;
               r_wvalid    <= 1'b0;
               r_bready    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hawk_tbl_wr_mngr.sv
// Directed bench for hawk_tbl_wr_mngr: cacheline addressing, strobes, handshake ordering,
// bus error, back-to-back packets, busy-request rejection and mid-transaction reset.
module tb_hawk_tbl_wr_mngr;

   localparam logic [63:0] ATT_B_ADDR = 64'h0000_0000_1000_0000;
   localparam logic [63:0] LST_B_ADDR = 64'h0000_0000_2000_0000;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          tbl_update;
   logic [15:0]   upd_att_id;
   logic [63:0]   upd_att_entry;
   logic [15:0]   upd_tol_id;
   logic [127:0]  upd_lst_entry;
   logic [15:0]   upd_lst_next;
   logic          upd_ready;
   logic          awvalid;
   logic          awready;
   logic [63:0]   awaddr;
   logic          wvalid;
   logic          wready;
   logic [511:0]  wdata;
   logic [63:0]   wstrb;
   logic          wlast;
   logic          bvalid;
   logic [1:0]    bresp;
   logic          bready;
   logic          head_upd;
   logic [15:0]   head_new;
   logic          wr_error;

   int n_checks = 0;
   int n_errors = 0;

   hawk_tbl_wr_mngr #(
      .ATT_BASE(ATT_B_ADDR), .LST_BASE(LST_B_ADDR),
      .ATT_ID_W(16), .LST_ID_W(16), .AXI_DW(512)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .tbl_update(tbl_update),
      .upd_att_id(upd_att_id), .upd_att_entry(upd_att_entry),
      .upd_tol_id(upd_tol_id), .upd_lst_entry(upd_lst_entry), .upd_lst_next(upd_lst_next),
      .upd_ready(upd_ready), .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .bvalid(bvalid), .bresp(bresp), .bready(bready),
      .head_upd(head_upd), .head_new(head_new), .wr_error(wr_error)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_fields(input logic [15:0] aid, input logic [63:0] aent,
                             input logic [15:0] tid, input logic [127:0] lent,
                             input logic [15:0] nxt);
      upd_att_id    = aid;
      upd_att_entry = aent;
      upd_tol_id    = tid;
      upd_lst_entry = lent;
      upd_lst_next  = nxt;
   endtask

   // Full update with awready=wready=1 and each B returned one cycle after W; ends on the head_upd cycle.
   task automatic do_update(input string tag,
                            input logic [15:0] aid, input logic [63:0] aent,
                            input logic [15:0] tid, input logic [127:0] lent,
                            input logic [15:0] nxt,
                            input logic [63:0] exp_aaddr, input logic [63:0] exp_astrb,
                            input logic [63:0] exp_laddr, input logic [63:0] exp_lstrb);
      set_fields(aid, aent, tid, lent, nxt);
      tbl_update = 1'b1;
      tick();
      tbl_update = 1'b0;
      chk({tag, " ready_drop"}, upd_ready, 1'b0);
      tick();
      chk({tag, " att_awvalid"}, awvalid, 1'b1);
      chk({tag, " att_wvalid"}, wvalid, 1'b1);
      chk({tag, " att_awaddr"}, awaddr, exp_aaddr);
      chk({tag, " att_wstrb"}, wstrb, exp_astrb);
      chk({tag, " att_wdata"}, wdata, {8{aent}});
      chk({tag, " wlast"}, wlast, 1'b1);
      tick();
      chk({tag, " att_valid_drop"}, {awvalid, wvalid}, 2'b00);
      chk({tag, " att_bready"}, bready, 1'b1);
      bvalid = 1'b1;
      bresp  = 2'b00;
      tick();
      bvalid = 1'b0;
      chk({tag, " att_bready_drop"}, bready, 1'b0);
      chk({tag, " no_early_lst"}, awvalid, 1'b0);
      tick();
      chk({tag, " lst_valids"}, {awvalid, wvalid}, 2'b11);
      chk({tag, " lst_awaddr"}, awaddr, exp_laddr);
      chk({tag, " lst_wstrb"}, wstrb, exp_lstrb);
      chk({tag, " lst_wdata"}, wdata, {4{lent}});
      tick();
      chk({tag, " lst_bready"}, bready, 1'b1);
      bvalid = 1'b1;
      tick();
      bvalid = 1'b0;
      chk({tag, " head_not_yet"}, head_upd, 1'b0);
      tick();
      chk({tag, " head_upd_lat7"}, head_upd, 1'b1);
      chk({tag, " head_new"}, head_new, nxt);
      chk({tag, " ready_back"}, upd_ready, 1'b1);
      chk({tag, " no_error"}, wr_error, 1'b0);
   endtask

   initial begin
      rst_i      = 1'b1;
      tbl_update = 1'b0;
      awready    = 1'b1;
      wready     = 1'b1;
      bvalid     = 1'b0;
      bresp      = 2'b00;
      set_fields(16'h0, 64'h0, 16'h0, 128'h0, 16'h0);
      tick();
      tick();
      chk("rst upd_ready", upd_ready, 1'b1);
      chk("rst valids", {awvalid, wvalid, bready, head_upd, wr_error}, 5'b00000);
      chk("rst awaddr", awaddr, 64'h0);
      chk("rst wdata", wdata, 512'h0);
      chk("rst wstrb", wstrb, 64'h0);
      chk("rst head_new", head_new, 16'h0);
      rst_i = 1'b0;
      tick();

      // Basic update: att_id 9 -> line 1 slot 1, tol_id 6 -> line 1 slot 2.
      do_update("t1", 16'd9, 64'hDEAD_BEEF_0123_4567, 16'd6,
                128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF, 16'h0042,
                64'h0000_0000_1000_0040, 64'h0000_0000_0000_FF00,
                64'h0000_0000_2000_0040, 64'h0000_FFFF_0000_0000);
      tick();
      chk("t1 head_pulse_end", head_upd, 1'b0);

      // W accepted 3 cycles after AW; a request while busy must be ignored.
      set_fields(16'd2, 64'hA5A5_0000_FFFF_1234, 16'd3,
                 128'hCAFE_0000_0000_0001_0000_0000_0000_BEEF, 16'h0007);
      wready     = 1'b0;
      tbl_update = 1'b1;
      tick();
      tbl_update = 1'b0;
      tick();
      chk("t2 att_awaddr", awaddr, 64'h0000_0000_1000_0000);
      chk("t2 att_wstrb", wstrb, 64'h0000_0000_00FF_0000);
      tick();
      chk("t2 aw_drop", awvalid, 1'b0);
      chk("t2 w_held", wvalid, 1'b1);
      set_fields(16'hFFF0, 64'h1111_1111_1111_1111, 16'hFFF1, 128'h2222, 16'h3333);
      tbl_update = 1'b1;
      tick();
      tbl_update = 1'b0;
      chk("t2 w_held2", wvalid, 1'b1);
      chk("t2 awaddr_stable", awaddr, 64'h0000_0000_1000_0000);
      chk("t2 wstrb_stable", wstrb, 64'h0000_0000_00FF_0000);
      chk("t2 wdata_stable", wdata, {8{64'hA5A5_0000_FFFF_1234}});
      chk("t2 busy_ready", upd_ready, 1'b0);
      tick();
      chk("t2 w_held3", wvalid, 1'b1);
      chk("t2 no_bready", bready, 1'b0);
      wready = 1'b1;
      tick();
      chk("t2 w_drop", {awvalid, wvalid}, 2'b00);
      chk("t2 att_bready", bready, 1'b1);
      bvalid = 1'b1;
      tick();
      bvalid = 1'b0;
      tick();
      chk("t2 lst_awaddr", awaddr, 64'h0000_0000_2000_0000);
      chk("t2 lst_wstrb", wstrb, 64'hFFFF_0000_0000_0000);
      chk("t2 lst_wdata", wdata, {4{128'hCAFE_0000_0000_0001_0000_0000_0000_BEEF}});
      tick();
      chk("t2 lst_bready", bready, 1'b1);
      bvalid = 1'b1;
      tick();
      bvalid = 1'b0;
      tick();
      chk("t2 head_upd", head_upd, 1'b1);
      chk("t2 head_new", head_new, 16'h0007);
      tick();

      // SLVERR on the ATT write: sticky error, no LST write, no head pulse, requests ignored.
      set_fields(16'd17, 64'h0BAD_0BAD_0BAD_0BAD, 16'd5, 128'h5555, 16'h0055);
      tbl_update = 1'b1;
      tick();
      tbl_update = 1'b0;
      tick();
      chk("t3 att_awaddr", awaddr, 64'h0000_0000_1000_0080);
      chk("t3 att_wstrb", wstrb, 64'h0000_0000_0000_FF00);
      tick();
      chk("t3 att_bready", bready, 1'b1);
      bvalid = 1'b1;
      bresp  = 2'b10;
      tick();
      bvalid = 1'b0;
      bresp  = 2'b00;
      chk("t3 wr_error", wr_error, 1'b1);
      chk("t3 bready_drop", bready, 1'b0);
      tbl_update = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         tbl_update = 1'b0;
         chk("t3 err_no_axi", {awvalid, wvalid, bready}, 3'b000);
         chk("t3 err_no_head", head_upd, 1'b0);
         chk("t3 err_not_ready", upd_ready, 1'b0);
         chk("t3 err_sticky", wr_error, 1'b1);
      end
      rst_i = 1'b1;
      tick();
      chk("t3 rst_clears_err", wr_error, 1'b0);
      chk("t3 rst_ready", upd_ready, 1'b1);
      rst_i = 1'b0;
      tick();

      // Back-to-back: packet 2 requested on the first cycle upd_ready is back; wrap-around indices.
      do_update("t4a", 16'hFFFF, 64'hFEDC_BA98_7654_3210, 16'hFFFF,
                128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888, 16'h1234,
                64'h0000_0000_1007_FFC0, 64'hFF00_0000_0000_0000,
                64'h0000_0000_200F_FFC0, 64'hFFFF_0000_0000_0000);
      do_update("t4b", 16'h0005, 64'h0123_0123_0123_0123, 16'h0101,
                128'h0F0F_0F0F_0F0F_0F0F_F0F0_F0F0_F0F0_F0F0, 16'h0ABC,
                64'h0000_0000_1000_0000, 64'h0000_FF00_0000_0000,
                64'h0000_0000_2000_1000, 64'h0000_0000_FFFF_0000);
      tick();

      // Reset asserted while waiting for the list B response.
      set_fields(16'd24, 64'h7777_7777_7777_7777, 16'd8, 128'h8888, 16'h0088);
      tbl_update = 1'b1;
      tick();
      tbl_update = 1'b0;
      tick();
      tick();
      bvalid = 1'b1;
      tick();
      bvalid = 1'b0;
      tick();
      chk("t5 lst_awaddr", awaddr, 64'h0000_0000_2000_0080);
      chk("t5 lst_wstrb", wstrb, 64'h0000_0000_0000_FFFF);
      tick();
      chk("t5 in_lst_b", bready, 1'b1);
      #2;
      rst_i = 1'b1;
      #1;
      chk("t5 async_clear", {awvalid, wvalid, bready, head_upd}, 4'b0000);
      chk("t5 async_awaddr", awaddr, 64'h0);
      tick();
      rst_i = 1'b0;
      tick();
      chk("t5 ready_after", upd_ready, 1'b1);
      chk("t5 no_head", head_upd, 1'b0);
      do_update("t5r", 16'd1, 64'h4242_4242_4242_4242, 16'd4,
                128'h9999_0000_9999_0000_9999_0000_9999_0000, 16'h0009,
                64'h0000_0000_1000_0000, 64'h0000_0000_0000_FF00,
                64'h0000_0000_2000_0040, 64'h0000_0000_0000_FFFF);
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
